// File: rtl/axi_lite_multi_adder.sv
// AXI4-Lite register file that sums NUM_OPERANDS unsigned operands one per cycle; `ADDER_SATURATE_EN clamps RESULT_LO on overflow.
// Latency: AW/W ready 1 cycle after both valids, B the cycle after; AR ready 1 cycle after arvalid, R the cycle after; sum takes NUM_OPERANDS+1 cycles.
// Backpressure: bvalid/rvalid and their payload hold until bready/rready; no new AW/AR is taken until the response completes.
module axi_lite_multi_adder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_OPERANDS = 4,
  parameter int RESP_WIDTH   = 2
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [RESP_WIDTH-1:0]   s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [RESP_WIDTH-1:0]   s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);
  localparam int CW    = $clog2(NUM_OPERANDS);
  localparam int ACC_W = DATA_WIDTH + CW;
  localparam int SW    = DATA_WIDTH / 8;
  localparam int IW    = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] CTRL_W   = IW'(16);
  localparam logic [IW-1:0] STATUS_W = IW'(17);
  localparam logic [IW-1:0] RES_LO_W = IW'(18);
  localparam logic [IW-1:0] RES_HI_W = IW'(19);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;
  typedef enum logic [1:0] {C_IDLE, C_LOAD, C_DONE} c_state_t;

  w_state_t w_state_q, w_state_d;
  r_state_t r_state_q, r_state_d;
  c_state_t c_state_q, c_state_d;
  logic [DATA_WIDTH-1:0] op_q [NUM_OPERANDS];
  logic [DATA_WIDTH-1:0] op_d [NUM_OPERANDS];
  logic [ACC_W-1:0]      acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic                  done_q, done_d, ovf_q, ovf_d;
  logic [RESP_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] res_lo;
  logic [IW-1:0]         wr_word, rd_word;
  logic                  busy;
  logic                  unused_addr_bits;

  assign wr_word = s1_axi_awaddr[ADDR_WIDTH-1:2];
  assign rd_word = s1_axi_araddr[ADDR_WIDTH-1:2];
  assign busy    = (c_state_q != C_IDLE);
  assign unused_addr_bits = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

`ifdef ADDER_SATURATE_EN
  assign res_lo = ovf_q ? '1 : result_q[DATA_WIDTH-1:0];
`else
  assign res_lo = result_q[DATA_WIDTH-1:0];
`endif

  // Compute and write paths share one process: CLEAR must override a result latched in the same cycle.
  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    op_d      = op_q;
    c_state_d = c_state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    result_d  = result_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    case (c_state_q)
      C_LOAD: begin
        acc_d = acc_q + ACC_W'(op_q[idx_q]);
        if (idx_q == CW'(NUM_OPERANDS - 1)) c_state_d = C_DONE;
        else idx_d = idx_q + CW'(1);
      end
      C_DONE: begin
        result_d  = acc_q;
        ovf_d     = |acc_q[ACC_W-1:DATA_WIDTH];
        done_d    = 1'b1;
        c_state_d = C_IDLE;
      end
      default: ;
    endcase
    case (w_state_q)
      W_IDLE: if (s1_axi_awvalid && s1_axi_wvalid) w_state_d = W_ACK;
      W_ACK: begin
        w_state_d = W_RESP;
        bresp_d   = RESP_OKAY;
        if (wr_word < IW'(NUM_OPERANDS)) begin
          if (busy) bresp_d = RESP_SLVERR;
          else begin
            for (int i = 0; i < NUM_OPERANDS; i++) begin
              if (wr_word == IW'(i)) begin
                for (int b = 0; b < SW; b++) begin
                  if (s1_axi_wstrb[b]) op_d[i][8*b +: 8] = s1_axi_wdata[8*b +: 8];
                end
              end
            end
          end
        end else if (wr_word == CTRL_W) begin
          if (s1_axi_wstrb[0] && s1_axi_wdata[1]) begin
            for (int i = 0; i < NUM_OPERANDS; i++) op_d[i] = '0;
            result_d = '0;
            ovf_d    = 1'b0;
            done_d   = 1'b0;
          end else if (s1_axi_wstrb[0] && s1_axi_wdata[0]) begin
            if (busy) bresp_d = RESP_SLVERR;
            else begin
              c_state_d = C_LOAD;
              acc_d     = '0;
              idx_d     = '0;
              done_d    = 1'b0;
            end
          end
        end else begin
          bresp_d = RESP_SLVERR;
        end
      end
      W_RESP: if (s1_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (s1_axi_arvalid) r_state_d = R_ACK;
      R_ACK: begin
        r_state_d = R_DATA;
        rdata_d   = '0;
        rresp_d   = RESP_OKAY;
        if (rd_word < IW'(NUM_OPERANDS)) begin
          for (int i = 0; i < NUM_OPERANDS; i++) begin
            if (rd_word == IW'(i)) rdata_d = op_q[i];
          end
        end else if (rd_word == CTRL_W) rdata_d = '0;
        else if (rd_word == STATUS_W) rdata_d = DATA_WIDTH'({ovf_q, done_q, busy});
        else if (rd_word == RES_LO_W) rdata_d = res_lo;
        else if (rd_word == RES_HI_W) rdata_d = DATA_WIDTH'(result_q[ACC_W-1:DATA_WIDTH]);
        else rresp_d = RESP_SLVERR;
      end
      R_DATA: if (s1_axi_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (s1_axi_areset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      c_state_q <= C_IDLE;
      op_q      <= '{default: '0};
      acc_q     <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      c_state_q <= c_state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s1_axi_awready = (w_state_q == W_ACK);
  assign s1_axi_wready  = (w_state_q == W_ACK);
  assign s1_axi_bvalid  = (w_state_q == W_RESP);
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = (r_state_q == R_ACK);
  assign s1_axi_rvalid  = (r_state_q == R_DATA);
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_multi_adder.sv
// Randomized AXI-Lite traffic against a register-level model of the adder, plus literal checks of the documented scenarios.
module tb_axi_lite_multi_adder;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  axi_lite_multi_adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_OPERANDS(N), .RESP_WIDTH(2)) dut (
    .s1_axi_aclk(clk), .s1_axi_areset(areset),
    .s1_axi_awaddr(awaddr), .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
    .s1_axi_wdata(wdata), .s1_axi_wstrb(wstrb), .s1_axi_wvalid(wvalid), .s1_axi_wready(wready),
    .s1_axi_bresp(bresp), .s1_axi_bvalid(bvalid), .s1_axi_bready(bready),
    .s1_axi_araddr(araddr), .s1_axi_arvalid(arvalid), .s1_axi_arready(arready),
    .s1_axi_rdata(rdata), .s1_axi_rresp(rresp), .s1_axi_rvalid(rvalid), .s1_axi_rready(rready)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out, got no handshake want one", nm);
  endtask

  // Register-level model: operand array, committed result, and one pending sum that lands N+2 cycles after its START.
  logic [31:0] m_op [N];
  logic [33:0] m_res, pend_sum;
  logic        m_ovf, m_done, pend;
  int          pend_cyc;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_op[i] = '0;
    m_res = '0; m_ovf = 1'b0; m_done = 1'b0; pend = 1'b0;
  endfunction

  function automatic void m_settle(input int c);
    if (pend && c >= pend_cyc + N + 2) begin
      m_res  = pend_sum;
      m_ovf  = (pend_sum[33:32] != 2'b00);
      m_done = 1'b1;
      pend   = 1'b0;
    end
  endfunction

  function automatic logic [31:0] m_lo();
`ifdef ADDER_SATURATE_EN
    return m_ovf ? 32'hFFFF_FFFF : m_res[31:0];
`else
    return m_res[31:0];
`endif
  endfunction

  function automatic void m_read(input int c, input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int w;
    w = int'(a[7:2]);
    m_settle(c);
    d = '0;
    r = 2'b00;
    if (w < N) d = m_op[w];
    else if (w == 16) d = '0;
    else if (w == 17) d = {29'd0, m_ovf, m_done, pend};
    else if (w == 18) d = m_lo();
    else if (w == 19) d = {30'd0, m_res[33:32]};
    else r = 2'b10;
  endfunction

  function automatic void m_write(input int c, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                                  output logic [1:0] r);
    int w;
    w = int'(a[7:2]);
    m_settle(c);
    r = 2'b00;
    if (w < N) begin
      if (pend) r = 2'b10;
      else for (int b = 0; b < 4; b++) if (s[b]) m_op[w][8*b +: 8] = d[8*b +: 8];
    end else if (w == 16) begin
      if (s[0] && d[1]) begin
        for (int i = 0; i < N; i++) m_op[i] = '0;
        m_res = '0; m_ovf = 1'b0; m_done = 1'b0;
      end else if (s[0] && d[0]) begin
        if (pend) r = 2'b10;
        else begin
          pend = 1'b1; pend_cyc = c; m_done = 1'b0; pend_sum = '0;
          for (int i = 0; i < N; i++) pend_sum = pend_sum + 34'(m_op[i]);
        end
      end
    end else r = 2'b10;
  endfunction

  // Monitor: every cycle compares handshakes and response payloads with the model.
  int         cyc = 0;
  int         wst = 0, rst_st = 0;
  logic       prev_rst = 1'b0;
  logic [1:0] exp_b, exp_rr;
  logic [31:0] exp_rd;

  always @(negedge clk) begin
    cyc++;
    if (prev_rst) begin
      chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);   chk("rst_bresp", bresp, 0);
      chk("rst_arready", arready, 0); chk("rst_rvalid", rvalid, 0);
      chk("rst_rresp", rresp, 0);     chk("rst_rdata", rdata, 0);
      m_reset();
      wst = 0;
      rst_st = 0;
    end
    chk("awready", awready, wst == 1);
    chk("wready", wready, wst == 1);
    chk("bvalid", bvalid, wst == 2);
    chk("arready", arready, rst_st == 1);
    chk("rvalid", rvalid, rst_st == 2);
    if (rst_st == 2) begin
      chk("rdata", rdata, exp_rd);
      chk("rresp", rresp, exp_rr);
    end
    if (wst == 2) chk("bresp", bresp, exp_b);
    if (!areset) begin
      case (rst_st)
        0: if (arvalid) rst_st = 1;
        1: begin m_read(cyc, araddr, exp_rd, exp_rr); rst_st = 2; end
        default: if (rready) rst_st = 0;
      endcase
      case (wst)
        0: if (awvalid && wvalid) wst = 1;
        1: begin m_write(cyc, awaddr, wdata, wstrb, exp_b); wst = 2; end
        default: if (bready) wst = 0;
      endcase
    end
    prev_rst = areset;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int hold,
                           output logic [1:0] resp);
    int n;
    resp = 2'bxx;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 100);
    if (!awready) begin tmo("aw_wait"); @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; return; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (!bvalid) begin tmo("b_wait"); return; end
    // Offer a second write while B is stalled; it must not be taken.
    repeat (hold) begin @(posedge clk); #1; awvalid = 1'b1; wvalid = 1'b1; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, input int hold, output logic [31:0] d, output logic [1:0] resp);
    int n;
    d = 'x; resp = 2'bxx;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 100);
    if (!arready) begin tmo("ar_wait"); @(posedge clk); #1; arvalid = 1'b0; return; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (!rvalid) begin tmo("r_wait"); return; end
    repeat (hold) begin @(posedge clk); #1; arvalid = 1'b1; end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test want end of test");
    $fatal(1);
  end

  logic [1:0]  br, rr, br2;
  logic [31:0] rd, rdat;
  logic [7:0]  addr_tab [13];
  logic [7:0]  a;
  int          sel;

  initial begin
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h10, 8'h3C, 8'h50, 8'h7C, 8'hFC};
    m_reset();
    idle(3);
    areset = 1'b0;
    axi_read(8'h44, 0, rd, rr); chk("status_after_reset", rd, 0);

    for (int i = 0; i < N; i++) axi_write(8'(4 * i), 32'(i + 1), 4'hF, 0, br);
    axi_write(8'h40, 32'h1, 4'h1, 0, br); chk("start_okay", br, 0);
    axi_read(8'h44, 0, rd, rr); chk("status_busy", rd, 32'h1);
    idle(8);
    axi_read(8'h48, 0, rd, rr); chk("sum_lo_10", rd, 32'd10);
    axi_read(8'h4C, 0, rd, rr); chk("sum_hi_0", rd, 0);
    axi_read(8'h44, 0, rd, rr); chk("status_done", rd, 32'h2);

    for (int i = 0; i < N; i++) axi_write(8'(4 * i), 32'hFFFF_FFFF, 4'hF, 0, br);
    axi_write(8'h40, 32'h1, 4'h1, 0, br);
    idle(8);
    axi_read(8'h4C, 0, rd, rr); chk("ovf_hi", rd, 32'd3);
    axi_read(8'h48, 0, rd, rr);
`ifdef ADDER_SATURATE_EN
    chk("ovf_lo", rd, 32'hFFFF_FFFF);
`else
    chk("ovf_lo", rd, 32'hFFFF_FFFC);
`endif
    axi_read(8'h44, 0, rd, rr); chk("status_ovf", rd, 32'h6);

    axi_write(8'h00, 32'h1122_3344, 4'hF, 0, br);
    axi_write(8'h00, 32'hAABB_CCDD, 4'b0101, 0, br);
    axi_read(8'h00, 0, rd, rr); chk("strobe_merge", rd, 32'h11BB_33DD);

    axi_write(8'h40, 32'h1, 4'h1, 0, br);
    axi_write(8'h04, 32'h55, 4'hF, 0, br); chk("op_write_busy", br, 2'b10);
    idle(8);
    axi_read(8'h04, 0, rd, rr); chk("op_unchanged", rd, 32'hFFFF_FFFF);
    axi_read(8'h4C, 0, rd, rr); chk("busy_sum_hi", rd, 32'd3);
    axi_read(8'h48, 0, rd, rr);
`ifdef ADDER_SATURATE_EN
    chk("busy_sum_lo", rd, 32'hFFFF_FFFF);
`else
    chk("busy_sum_lo", rd, 32'h11BB_33DA);
`endif
    axi_write(8'h40, 32'h1, 4'h1, 0, br);
    axi_write(8'h40, 32'h1, 4'h1, 0, br); chk("start_busy", br, 2'b10);
    idle(8);
    axi_read(8'h7C, 0, rd, rr); chk("unmapped_rresp", rr, 2'b10); chk("unmapped_rdata", rd, 0);

    fork
      axi_write(8'h08, 32'hCAFE_F00D, 4'hF, 5, br);
      axi_read(8'h00, 5, rd, rr);
    join
    chk("hold_bresp", br, 0);
    chk("hold_rdata", rd, 32'h11BB_33DD);

    axi_write(8'h40, 32'h1, 4'h1, 0, br);
    areset = 1'b1;
    idle(1);
    areset = 1'b0;
    axi_read(8'h00, 0, rd, rr); chk("op_after_abort", rd, 0);
    axi_read(8'h44, 0, rd, rr); chk("status_after_abort", rd, 0);
    axi_write(8'h40, 32'h1, 4'h1, 0, br);
    idle(8);
    axi_read(8'h48, 0, rd, rr); chk("zero_sum", rd, 0);

    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      a = addr_tab[$urandom_range(0, 12)] | 8'($urandom_range(0, 3));
      case (sel)
        0, 1, 2, 3: axi_write(8'(4 * $urandom_range(0, N - 1)),
                              ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom(),
                              4'($urandom_range(1, 15)), $urandom_range(0, 2), br);
        4: axi_write(8'h40, 32'h1, {3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0)}, $urandom_range(0, 2), br);
        5: begin
          m_settle(cyc);
          if (!pend) axi_write(8'h40, 32'h2, 4'h1, 0, br);
        end
        6: axi_write(a, $urandom() & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), $urandom_range(0, 2), br);
        7, 8: axi_read(a, $urandom_range(0, 2), rd, rr);
        default: fork
          axi_write(8'(4 * $urandom_range(0, N - 1)), $urandom(), 4'hF, $urandom_range(0, 2), br2);
          axi_read(a, $urandom_range(0, 2), rdat, rr);
        join
      endcase
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 8));
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
